// File: rtl/dcache_axi_wr.sv
// Write-back AXI4 burst master: drains one cacheline from the dcache write FIFO
// as a single INCR burst on AW/W/B and reports acceptance/completion back.
module dcache_axi_wr #(
    parameter int         LINE_WIDTH     = 128,
    parameter int         AXI_DATA_WIDTH = 32,
    parameter logic [3:0] AXI_ID         = 4'h1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wen_i,
    input  logic [LINE_WIDTH-1:0]       wdata_i,
    input  logic [31:0]                 awaddr_i,
    output logic                        req_accept_o,
    output logic                        bvalid_o,
    output logic                        err_o,
    output logic [3:0]                  awid_o,
    output logic [31:0]                 awaddr_o,
    output logic [7:0]                  awlen_o,
    output logic [2:0]                  awsize_o,
    output logic [1:0]                  awburst_o,
    output logic                        awvalid_o,
    input  logic                        awready_i,
    output logic [AXI_DATA_WIDTH-1:0]   wdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0] wstrb_o,
    output logic                        wlast_o,
    output logic                        wvalid_o,
    input  logic                        wready_i,
    input  logic [3:0]                  bid_i,
    input  logic [1:0]                  bresp_i,
    input  logic                        bvalid_i,
    output logic                        bready_o
);

    localparam int                BURST_LEN = LINE_WIDTH / AXI_DATA_WIDTH;
    localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [7:0]        AWLEN     = 8'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                                      r_state;
    state_t                                      w_state_nxt;
    logic [LINE_WIDTH-1:0]                       r_line;
    logic [31:0]                                 r_addr;
    logic                                        r_aw_done;
    logic                                        r_w_done;
    logic [BEAT_W-1:0]                           r_beat;
    logic                                        r_err;
    logic [BURST_LEN-1:0][AXI_DATA_WIDTH-1:0]    w_beats;
    logic                                        w_aw_hs;
    logic                                        w_w_hs;
    logic                                        w_b_hs;
    logic                                        w_unused;

    assign w_beats  = r_line;
    assign w_unused = ^bid_i;

    // req_accept_o/bvalid_o are gated by rst so they stay low while reset is held
    assign req_accept_o = rst && (r_state == ST_IDLE) && wen_i;
    assign awvalid_o    = (r_state == ST_BUSY) && !r_aw_done;
    assign wvalid_o     = (r_state == ST_BUSY) && !r_w_done;
    assign wlast_o      = wvalid_o && (r_beat == LAST_BEAT);
    assign bready_o     = (r_state == ST_RESP);
    assign bvalid_o     = rst && bready_o && bvalid_i;

    assign w_aw_hs = awvalid_o && awready_i;
    assign w_w_hs  = wvalid_o && wready_i;
    assign w_b_hs  = bvalid_o;

    assign awid_o    = AXI_ID;
    assign awaddr_o  = r_addr;
    assign awlen_o   = AWLEN;
    assign awsize_o  = 3'b010;
    assign awburst_o = 2'b01;
    assign wdata_o   = w_beats[r_beat];
    assign wstrb_o   = {(AXI_DATA_WIDTH/8){1'b1}};
    assign err_o     = r_err;

    // Next-state decode; AW and W may finish in either order or together
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_accept_o) begin
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || (w_w_hs && wlast_o))) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_RESP: begin
                if (w_b_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Line buffer, address and per-channel progress; beat counter stops at the last beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_line    <= '0;
            r_addr    <= 32'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_beat    <= '0;
        end else if (req_accept_o) begin
            r_line    <= wdata_i;
            r_addr    <= awaddr_i;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_beat    <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                if (r_beat == LAST_BEAT) begin
                    r_w_done <= 1'b1;
                end else begin
                    r_beat <= r_beat + BEAT_W'(1);
                end
            end
        end
    end

    // Sticky error flag; only reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_b_hs && (bresp_i != 2'b00)) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_axi_wr.sv
// Directed bench for dcache_axi_wr: expected AW/W traffic is queued when a line
// is offered and popped as the DUT hands shakes each beat.
module tb_dcache_axi_wr;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wen_i = 1'b0;
    logic [127:0] wdata_i = '0;
    logic [31:0]  awaddr_i = 32'd0;
    logic         req_accept_o, bvalid_o, err_o;
    logic [3:0]   awid_o;
    logic [31:0]  awaddr_o;
    logic [7:0]   awlen_o;
    logic [2:0]   awsize_o;
    logic [1:0]   awburst_o;
    logic         awvalid_o;
    logic         awready_i = 1'b0;
    logic [31:0]  wdata_o;
    logic [3:0]   wstrb_o;
    logic         wlast_o, wvalid_o;
    logic         wready_i = 1'b0;
    logic [3:0]   bid_i = 4'h0;
    logic [1:0]   bresp_i = 2'b00;
    logic         bvalid_i = 1'b0;
    logic         bready_o;

    always #5 clk = ~clk;

    dcache_axi_wr dut (
        .clk(clk), .rst(rst), .wen_i(wen_i), .wdata_i(wdata_i), .awaddr_i(awaddr_i),
        .req_accept_o(req_accept_o), .bvalid_o(bvalid_o), .err_o(err_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
        .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
        .wready_i(wready_i), .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i),
        .bready_o(bready_o)
    );

    int          errs = 0;
    int          checks = 0;
    int          acc_cnt = 0;
    int          bv_cnt = 0;
    int          acc0 = 0;
    logic [32:0] exp_w[$];
    logic [31:0] exp_aw[$];
    logic        prev_w_stall = 1'b0;
    logic        prev_aw_stall = 1'b0;
    logic [33:0] prev_w = '0;
    logic [32:0] prev_aw = '0;
    int          wpat[7] = '{1, 0, 0, 1, 0, 1, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_line(input logic [127:0] line, input logic [31:0] addr);
        logic lb;
        wdata_i  = line;
        awaddr_i = addr;
        exp_aw.push_back(addr);
        for (int i = 0; i < 4; i++) begin
            lb = (i == 3);
            exp_w.push_back({lb, line[i*32 +: 32]});
        end
    endtask

    // One clock: drive inputs at negedge, sample 1ns later, score handshakes
    task automatic tick(input logic wen, input logic awr, input logic wr,
                        input logic bv, input logic [1:0] br);
        logic [32:0] ew;
        logic [31:0] ea;
        @(negedge clk);
        wen_i = wen; awready_i = awr; wready_i = wr; bvalid_i = bv; bresp_i = br;
        #1;
        if (prev_w_stall) chk("w_hold", 64'({wvalid_o, wlast_o, wdata_o}), 64'(prev_w));
        if (prev_aw_stall) chk("aw_hold", 64'({awvalid_o, awaddr_o}), 64'(prev_aw));
        if (wvalid_o && wready_i) begin
            chk("w_expected", 64'(exp_w.size() > 0), 64'd1);
            if (exp_w.size() > 0) begin
                ew = exp_w.pop_front();
                chk("w_beat", 64'({wstrb_o, wlast_o, wdata_o}), 64'({4'hF, ew}));
            end
        end
        if (awvalid_o && awready_i) begin
            chk("aw_expected", 64'(exp_aw.size() > 0), 64'd1);
            if (exp_aw.size() > 0) begin
                ea = exp_aw.pop_front();
                chk("aw_beat", 64'({awaddr_o, awlen_o, awsize_o, awburst_o, awid_o}),
                    64'({ea, 8'd3, 3'd2, 2'd1, 4'h1}));
            end
        end
        if (req_accept_o) acc_cnt++;
        if (bvalid_o) bv_cnt++;
        prev_w_stall  = wvalid_o && !wready_i;
        prev_w        = {wvalid_o, wlast_o, wdata_o};
        prev_aw_stall = awvalid_o && !awready_i;
        prev_aw       = {awvalid_o, awaddr_o};
    endtask

    initial begin
        // reset state with wen_i/bvalid_i driven high
        repeat (2) @(negedge clk);
        wen_i = 1'b1; bvalid_i = 1'b1; awaddr_i = 32'hFFFF_FFF0;
        #1;
        chk("rst_valids", 64'({awvalid_o, wvalid_o, bready_o, wlast_o, err_o}), 64'd0);
        chk("rst_pulses", 64'({req_accept_o, bvalid_o}), 64'd0);
        chk("rst_regs", 64'({awaddr_o, wdata_o}), 64'd0);
        wen_i = 1'b0; bvalid_i = 1'b0;
        rst = 1'b1;

        // always-ready slave
        push_line(128'h4444_4444_3333_3333_2222_2222_1111_1111, 32'h1C00_0040);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("t1_accept_c0", 64'(req_accept_o), 64'd1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("t1_aw_w_c1", 64'({awvalid_o, wvalid_o}), 64'd3);
        repeat (3) tick(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
        chk("t1_b_c5", 64'({bready_o, bvalid_o}), 64'd3);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("t1_idle_c6", 64'({bready_o, bvalid_o, awvalid_o, wvalid_o}), 64'd0);
        chk("t1_drained", 64'(exp_w.size() + exp_aw.size()), 64'd0);
        chk("t1_bcount", 64'(bv_cnt), 64'd1);

        // AWREADY held off for 6 cycles
        push_line(128'hDEAD_0003_DEAD_0002_DEAD_0001_DEAD_0000, 32'h0000_1230);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        repeat (6) tick(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        chk("t2_w_first", 64'({awvalid_o, wvalid_o, bready_o}), 64'd4);
        chk("t2_queues", 64'({16'(exp_w.size()), 16'(exp_aw.size())}), 64'h0000_0001);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        chk("t2_b", 64'({bready_o, bvalid_o}), 64'd3);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("t2_bcount", 64'({bv_cnt, 1'b0}), 64'({32'd2, bvalid_o}));

        // WREADY toggling
        push_line(128'hA5A5_0004_5A5A_0003_A5A5_0002_5A5A_0001, 32'h8000_0100);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        foreach (wpat[i]) tick(1'b0, 1'b1, wpat[i][0], 1'b0, 2'b00);
        chk("t3_drained", 64'(exp_w.size() + exp_aw.size()), 64'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        chk("t3_b", 64'({bready_o, bvalid_o}), 64'd3);

        // wen_i held high through BUSY/RESP
        push_line(128'h0F0F_0F0F_1E1E_1E1E_2D2D_2D2D_3C3C_3C3C, 32'h0000_0040);
        acc0 = acc_cnt;
        repeat (5) tick(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
        chk("t4_single_accept", 64'(acc_cnt - acc0), 64'd1);
        chk("t4_b", 64'({bvalid_o, req_accept_o}), 64'd2);
        push_line(128'h1357_9BDF_2468_ACE0_0BAD_F00D_CAFE_BABE, 32'h2000_0010);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("t4_recapture", 64'(req_accept_o), 64'd1);

        // SLVERR response, then an OKAY burst
        repeat (4) tick(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
        chk("t5_b_err", 64'(bvalid_o), 64'd1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("t5_err_set", 64'(err_o), 64'd1);
        push_line(128'h7777_7777_6666_6666_5555_5555_4444_4444, 32'h2000_0020);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        repeat (4) tick(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("t5_err_sticky", 64'(err_o), 64'd1);
        chk("t5_bcount", 64'(bv_cnt), 64'd6);

        // reset during beat 2
        push_line(128'hCCCC_0003_CCCC_0002_CCCC_0001_CCCC_0000, 32'h3000_0000);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        chk("t6_beat2_presented", 64'({wvalid_o, wdata_o}), 64'h1_CCCC_0002);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_async", 64'({awvalid_o, wvalid_o, wlast_o, bready_o, req_accept_o, bvalid_o, err_o}), 64'd0);
        exp_w.delete();
        exp_aw.delete();
        prev_w_stall = 1'b0;
        prev_aw_stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        push_line(128'h9999_0003_9999_0002_9999_0001_9999_0000, 32'h3000_0040);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("t6_accept_after_rst", 64'(req_accept_o), 64'd1);
        repeat (4) tick(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
        chk("t6_b", 64'({bready_o, bvalid_o}), 64'd3);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("t6_drained", 64'(exp_w.size() + exp_aw.size()), 64'd0);
        chk("t6_err_clear", 64'(err_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
